serial_to_parallel: RTL and testbench

//  Receive side of the load_neuron word stream. Captures a frame of NUM_WORDS

---
 rtl/serial_to_parallel.sv | 99 +++++++++
 tb/tb_serial_to_parallel.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel.sv
// Collects a frame of strobed stream words into a register buffer, exposed as a flat bus and an indexed read port.
// state   | meaning: IDLE wait for start edge | COLLECT capture words | DONE pulse valid
module serial_to_parallel #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 10,
  parameter int IDX_W     = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [DATA_W-1:0]           data_i,
  input  logic                        load_neuron,
  input  logic [IDX_W-1:0]            rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic [NUM_WORDS*DATA_W-1:0] parallel_o,
  output logic [IDX_W:0]              count,
  output logic                        busy,
  output logic                        valid,
  output logic                        err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]        state;
  logic              start_q;
  logic [TMR_W-1:0]  timer;
  logic [DATA_W-1:0] word_q [NUM_WORDS];
  logic              start_edge;

  assign start_edge = start & ~start_q;

  // Idle timer counts down from TIMEOUT; expiry at zero matches TIMEOUT+1 silent edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      timer   <= '0;
      count   <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      err     <= 1'b0;
      for (int k = 0; k < NUM_WORDS; k++) word_q[k] <= '0;
    end else begin
      start_q <= start;
      valid   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            count <= '0;
            err   <= load_neuron;
            timer <= TMR_W'(TIMEOUT);
            busy  <= 1'b1;
            state <= S_COLLECT;
          end else if (load_neuron) begin
            err <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (load_neuron) begin
            word_q[count[IDX_W-1:0]] <= data_i;
            if (count != (IDX_W+1)'(NUM_WORDS)) count <= count + 1'b1;
            timer <= TMR_W'(TIMEOUT);
            if (count == (IDX_W+1)'(NUM_WORDS - 1)) state <= S_DONE;
          end else if (timer == '0) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_DONE: begin
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
          if (load_neuron) err <= 1'b1;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_WORDS; g++) begin : g_flat
      assign parallel_o[g*DATA_W +: DATA_W] = word_q[g];
    end
  endgenerate

  assign rd_data = ({1'b0, rd_addr} < (IDX_W+1)'(NUM_WORDS)) ? word_q[rd_addr] : '0;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: scoreboard of captured words checked on frame completion.
module tb_serial_to_parallel;
  localparam int DATA_W = 32;
  localparam int NW     = 10;
  localparam int IDX_W  = 4;
  localparam int TMO    = 255;

  logic              clk, rst, start, load_neuron;
  logic [DATA_W-1:0] data_i, rd_data;
  logic [IDX_W-1:0]  rd_addr;
  logic [NW*DATA_W-1:0] parallel_o;
  logic [IDX_W:0]    count;
  logic              busy, valid, err;

  serial_to_parallel #(.DATA_W(DATA_W), .NUM_WORDS(NW), .IDX_W(IDX_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .data_i(data_i), .load_neuron(load_neuron),
    .rd_addr(rd_addr), .rd_data(rd_data), .parallel_o(parallel_o), .count(count),
    .busy(busy), .valid(valid), .err(err)
  );

  typedef struct {int idx; logic [DATA_W-1:0] data;} ent_t;
  ent_t sb[$];
  logic [DATA_W-1:0] mdl [NW];
  int checks = 0, failures = 0;
  int busy_cyc = 0, valid_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy) busy_cyc++;
    if (valid) valid_cnt++;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int idx, input logic [DATA_W-1:0] w, input bit track);
    ent_t e;
    load_neuron = 1'b1;
    data_i = w;
    if (track) begin
      e.idx = idx; e.data = w;
      sb.push_back(e);
    end
    tick();
    load_neuron = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 0;
    while (valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic check_frame(input string tag);
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("%s_par_w%0d", tag, e.idx), parallel_o[e.idx*DATA_W +: DATA_W], e.data);
      mdl[e.idx] = e.data;
    end
  endtask

  task automatic check_rd(input string tag);
    logic [DATA_W-1:0] exp;
    for (int k = 0; k < 12; k++) begin
      rd_addr = IDX_W'(k);
      #1;
      exp = (k < NW) ? mdl[k] : '0;
      chk($sformatf("%s_rd%0d", tag, k), rd_data, exp);
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; load_neuron = 1'b0; data_i = '0; rd_addr = '0;
    for (int k = 0; k < NW; k++) mdl[k] = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    chk("rst_par_zero", parallel_o == '0, 1);
    #9 rst = 1'b0;

    // back-to-back frame
    busy_cyc = 0; valid_cnt = 0;
    do_start();
    for (int i = 0; i < NW; i++) send(i, 32'h11 + i, 1'b1);
    chk("t1_busy_before_valid", busy, 1);
    wait_valid("t1", 1);
    chk("t1_busy_cycles", busy_cyc, 11);
    chk("t1_count", count, 10);
    chk("t1_err", err, 0);
    check_frame("t1");
    tick();
    chk("t1_valid_one_cycle", valid, 0);
    chk("t1_valid_cnt", valid_cnt, 1);
    check_rd("t1");

    // gaps of 3 idle cycles between strobes
    valid_cnt = 0;
    do_start();
    for (int i = 0; i < NW; i++) begin
      send(i, 32'h11 + i, 1'b1);
      if (i != NW - 1) repeat (3) tick();
    end
    wait_valid("t2", 1);
    chk("t2_count", count, 10);
    chk("t2_err", err, 0);
    check_frame("t2");
    tick();
    chk("t2_valid_cnt", valid_cnt, 1);

    // partial frame then timeout
    valid_cnt = 0;
    do_start();
    for (int i = 0; i < 4; i++) send(i, 32'hA0 + i, 1'b1);
    t = 0;
    while (err !== 1'b1 && t < 400) begin
      tick();
      t++;
    end
    chk("t3_timeout_cycles", t, TMO + 1);
    chk("t3_busy", busy, 0);
    chk("t3_count", count, 4);
    chk("t3_valid_cnt", valid_cnt, 0);
    check_frame("t3");
    check_rd("t3");
    do_start();
    chk("t3_err_cleared", err, 0);
    chk("t3_busy_rearm", busy, 1);
    for (int i = 0; i < NW; i++) send(i, 32'h31 + i, 1'b1);
    wait_valid("t3b", 1);
    check_frame("t3b");
    tick();

    // stray strobe while idle
    load_neuron = 1'b1; data_i = 32'hDEAD;
    tick();
    load_neuron = 1'b0;
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_count", count, 10);
    check_rd("t4");

    // start held high across a full frame
    valid_cnt = 0;
    start = 1'b1;
    tick();
    chk("t5_busy", busy, 1);
    chk("t5_err_cleared", err, 0);
    for (int i = 0; i < NW; i++) send(i, 32'h41 + i, 1'b1);
    wait_valid("t5", 1);
    check_frame("t5");
    repeat (18) tick();
    chk("t5_busy_held", busy, 0);
    chk("t5_valid_cnt", valid_cnt, 1);
    start = 1'b0;
    tick();
    chk("t5_busy_after_drop", busy, 0);
    do_start();
    chk("t5_busy_rearm", busy, 1);

    // async reset mid-frame
    for (int i = 0; i < 5; i++) send(i, 32'h51 + i, 1'b0);
    chk("t6_partial_w4", parallel_o[4*DATA_W +: DATA_W], 32'h55);
    #3 rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_count", count, 0);
    chk("t6_par_zero", parallel_o == '0, 1);
    for (int k = 0; k < NW; k++) mdl[k] = '0;
    #2 rst = 1'b0;
    valid_cnt = 0;
    do_start();
    for (int i = 0; i < NW; i++) send(i, 32'h61 + i, 1'b1);
    wait_valid("t6", 1);
    chk("t6_count_full", count, 10);
    check_frame("t6");
    do_start();
    chk("t6_start_on_valid", busy, 1);
    chk("t6_valid_cnt", valid_cnt, 1);
    check_rd("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
